// File: rtl/expr_pkg.sv
// Shared definitions for the expression evaluator: opcodes, error codes,
// operator precedence and FSM state encoding. Optional MOD via EXPR_MOD_OP_EN.
package expr_pkg;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MUL    = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd3;
    localparam logic [2:0] OP_LPAREN = 3'd4;
    localparam logic [2:0] OP_RPAREN = 3'd5;
    localparam logic [2:0] OP_MOD    = 3'd6;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_OVF   = 3'd1;
    localparam logic [2:0] ERR_UNF   = 3'd2;
    localparam logic [2:0] ERR_DIV0  = 3'd3;
    localparam logic [2:0] ERR_PAREN = 3'd4;
    localparam logic [2:0] ERR_BADOP = 3'd5;

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_REDUCE,
        S_FINISH,
        S_OUTPUT,
        S_DRAIN
    } state_t;

    function automatic logic is_binop(input logic [2:0] op);
        logic r;
        r = (op <= OP_DIV);
`ifdef EXPR_MOD_OP_EN
        r = r || (op == OP_MOD);
`endif
        return r;
    endfunction

    function automatic logic [1:0] prec(input logic [2:0] op);
        logic [1:0] p;
        case (op)
            OP_ADD, OP_SUB: p = 2'd1;
            OP_MUL, OP_DIV: p = 2'd2;
`ifdef EXPR_MOD_OP_EN
            OP_MOD:         p = 2'd2;
`endif
            default:        p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/expr_lifo.sv
// Register-file LIFO with top and second-from-top read ports.
// Ports: clk, rst (async high), clear, push, pop, wdata -> top, next, count.
module expr_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    widx;
    logic [PW-1:0]    tidx;
    logic [PW-1:0]    nidx;

    // push+pop together drops the top and overwrites the entry below it,
    // which is exactly "pop b, pop a, push result" in one cycle.
    assign widx  = (push && pop) ? ptr - PW'(2) : ptr;
    assign tidx  = ptr - PW'(1);
    assign nidx  = ptr - PW'(2);
    assign top   = mem[tidx[PW-2:0]];
    assign next  = mem[nidx[PW-2:0]];
    assign count = ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (push && pop) begin
            ptr <= ptr - PW'(1);
        end else if (push) begin
            ptr <= ptr + PW'(1);
        end else if (pop) begin
            ptr <= ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[widx[PW-2:0]] <= wdata;
        end
    end

endmodule

// File: rtl/expr_eval_core.sv
// Streaming infix evaluator: shunting-yard with reduce-at-push on two LIFOs.
// Ports: CLK, RST, input_* token handshake, result_* handshake. Macro: EXPR_MOD_OP_EN.
import expr_pkg::*;

module expr_eval_core #(
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              input_stb,
    input  logic [DATA_W-1:0] input_data,
    input  logic              is_input_operator,
    input  logic              input_last,
    output logic              input_ack,
    output logic              result_stb,
    output logic [DATA_W-1:0] result_data,
    output logic [2:0]        result_err,
    input  logic              result_ack
);

    localparam int PW = $clog2(STACK_DEPTH) + 1;

    state_t            state;
    logic [2:0]        err_q;
    logic [2:0]        nxt_err;
    logic [2:0]        tok_op;
    logic [2:0]        op_top;
    logic [2:0]        unused_op_next;
    logic [PW-1:0]     op_cnt;
    logic [PW-1:0]     val_cnt;
    logic [DATA_W-1:0] val_top;
    logic [DATA_W-1:0] val_next;
    logic [DATA_W-1:0] val_wdata;
    logic [DATA_W-1:0] alu_res;
    logic              alu_div0;
    logic              op_push, op_pop, val_push, val_pop;
    logic              stk_clear, do_ack, red;
    logic              op_empty, op_full, val_full, take;

    assign tok_op   = input_data[2:0];
    assign op_empty = (op_cnt == '0);
    assign op_full  = (op_cnt == PW'(STACK_DEPTH));
    assign val_full = (val_cnt == PW'(STACK_DEPTH));
    // Token stays on the bus during the ack cycle; never take it twice.
    assign take     = input_stb && !input_ack;

    expr_lifo #(.WIDTH(3), .DEPTH(STACK_DEPTH)) u_ops (
        .clk(CLK), .rst(RST), .clear(stk_clear),
        .push(op_push), .pop(op_pop), .wdata(tok_op),
        .top(op_top), .next(unused_op_next), .count(op_cnt)
    );

    expr_lifo #(.WIDTH(DATA_W), .DEPTH(STACK_DEPTH)) u_vals (
        .clk(CLK), .rst(RST), .clear(stk_clear),
        .push(val_push), .pop(val_pop), .wdata(val_wdata),
        .top(val_top), .next(val_next), .count(val_cnt)
    );

    // a = second from top, b = top
    always_comb begin
        logic signed [DATA_W-1:0] a, b;
        a        = val_next;
        b        = val_top;
        alu_res  = '0;
        alu_div0 = 1'b0;
        case (op_top)
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_MUL: alu_res = a * b;
            OP_DIV: begin
                if (b == '0)                alu_div0 = 1'b1;
                else if (b == {DATA_W{1'b1}}) alu_res = -a;
                else                        alu_res = a / b;
            end
`ifdef EXPR_MOD_OP_EN
            OP_MOD: begin
                if (b == '0)                alu_div0 = 1'b1;
                else if (b == {DATA_W{1'b1}}) alu_res = '0;
                else                        alu_res = a % b;
            end
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        op_push   = 1'b0;
        op_pop    = 1'b0;
        val_push  = 1'b0;
        val_pop   = 1'b0;
        val_wdata = input_data;
        stk_clear = 1'b0;
        do_ack    = 1'b0;
        red       = 1'b0;
        nxt_err   = ERR_NONE;
        case (state)
            S_ACCEPT, S_REDUCE: begin
                if (take) begin
                    if (!is_input_operator) begin
                        if (val_full) nxt_err = ERR_OVF;
                        else begin
                            val_push = 1'b1;
                            do_ack   = 1'b1;
                        end
                    end else if (is_binop(tok_op)) begin
                        if (!op_empty && is_binop(op_top) &&
                            prec(op_top) >= prec(tok_op))
                            red = 1'b1;
                        else if (op_full) nxt_err = ERR_OVF;
                        else begin
                            op_push = 1'b1;
                            do_ack  = 1'b1;
                        end
                    end else if (tok_op == OP_LPAREN) begin
                        if (op_full) nxt_err = ERR_OVF;
                        else begin
                            op_push = 1'b1;
                            do_ack  = 1'b1;
                        end
                    end else if (tok_op == OP_RPAREN) begin
                        if (op_empty) nxt_err = ERR_PAREN;
                        else if (op_top == OP_LPAREN) begin
                            op_pop = 1'b1;
                            do_ack = 1'b1;
                        end else red = 1'b1;
                    end else begin
                        nxt_err = ERR_BADOP;
                    end
                end
            end
            S_FINISH: begin
                if (err_q == ERR_NONE) begin
                    if (!op_empty) begin
                        if (op_top == OP_LPAREN) nxt_err = ERR_PAREN;
                        else red = 1'b1;
                    end else if (val_cnt != PW'(1)) begin
                        nxt_err = ERR_UNF;
                    end
                end
            end
            S_DRAIN: do_ack = take;
            S_OUTPUT: stk_clear = result_ack;
            default: ;
        endcase
        if (red) begin
            if (val_cnt < PW'(2)) nxt_err = ERR_UNF;
            else if (alu_div0)   nxt_err = ERR_DIV0;
            else begin
                op_pop    = 1'b1;
                val_pop   = 1'b1;
                val_push  = 1'b1;
                val_wdata = alu_res;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_ACCEPT;
            err_q       <= ERR_NONE;
            input_ack   <= 1'b0;
            result_stb  <= 1'b0;
            result_data <= '0;
            result_err  <= ERR_NONE;
        end else begin
            input_ack <= do_ack;
            case (state)
                S_ACCEPT, S_REDUCE: begin
                    if (nxt_err != ERR_NONE) begin
                        err_q <= nxt_err;
                        state <= S_DRAIN;
                    end else if (do_ack) begin
                        state <= input_last ? S_FINISH : S_ACCEPT;
                    end else if (red) begin
                        state <= S_REDUCE;
                    end else begin
                        state <= S_ACCEPT;
                    end
                end
                S_FINISH: begin
                    if (err_q != ERR_NONE || nxt_err != ERR_NONE) begin
                        result_stb  <= 1'b1;
                        result_data <= '0;
                        result_err  <= (err_q != ERR_NONE) ? err_q : nxt_err;
                        state       <= S_OUTPUT;
                    end else if (op_empty) begin
                        result_stb  <= 1'b1;
                        result_data <= val_top;
                        result_err  <= ERR_NONE;
                        state       <= S_OUTPUT;
                    end
                end
                S_DRAIN: begin
                    if (do_ack && input_last) state <= S_FINISH;
                end
                S_OUTPUT: begin
                    if (result_ack) begin
                        result_stb <= 1'b0;
                        err_q      <= ERR_NONE;
                        state      <= S_ACCEPT;
                    end
                end
                default: state <= S_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_expr_eval_core.sv
// Directed bench for expr_eval_core: token table plus handshake,
// latency and reset sequences. STACK_DEPTH=4, DATA_W=32.
import expr_pkg::*;

module tb_expr_eval_core;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        input_stb = 1'b0;
    logic [31:0] input_data = '0;
    logic        is_input_operator = 1'b0;
    logic        input_last = 1'b0;
    logic        input_ack;
    logic        result_stb;
    logic [31:0] result_data;
    logic [2:0]  result_err;
    logic        result_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    expr_eval_core #(.DATA_W(32), .STACK_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .input_stb(input_stb), .input_data(input_data),
        .is_input_operator(is_input_operator), .input_last(input_last),
        .input_ack(input_ack),
        .result_stb(result_stb), .result_data(result_data),
        .result_err(result_err), .result_ack(result_ack)
    );

    typedef struct packed {
        logic        op;
        logic        last;
        logic [31:0] val;
        logic [31:0] ed;
        logic [2:0]  ee;
    } vec_t;

    vec_t  vecs[$];
    string names[$];

    function automatic vec_t V(input logic [31:0] x);
        vec_t r;
        r = '0;
        r.val = x;
        return r;
    endfunction

    function automatic vec_t O(input logic [2:0] c);
        vec_t r;
        r = '0;
        r.op = 1'b1;
        r.val = {29'd0, c};
        return r;
    endfunction

    function automatic vec_t L(input vec_t t, input logic [31:0] d,
                               input logic [2:0] e);
        t.last = 1'b1;
        t.ed = d;
        t.ee = e;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input vec_t v, output int lat);
        @(posedge CLK); #1;
        input_stb = 1'b1;
        is_input_operator = v.op;
        input_data = v.val;
        input_last = v.last;
        lat = 0;
        while (lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (input_ack) break;
        end
        if (!input_ack) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack want ack within 40");
        end
        input_stb = 1'b0;
        input_last = 1'b0;
    endtask

    task automatic get_result(input string nm, input logic [31:0] d,
                              input logic [2:0] e);
        int n;
        n = 0;
        while (!result_stb && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({nm, "_stb"}, {31'd0, result_stb}, 32'd1);
        chk({nm, "_data"}, result_data, d);
        chk({nm, "_err"}, {29'd0, result_err}, {29'd0, e});
        result_ack = 1'b1;
        @(posedge CLK); #1;
        result_ack = 1'b0;
        chk({nm, "_drop"}, {31'd0, result_stb}, 32'd0);
    endtask

    task automatic run_expr(input string nm, input vec_t ts[$]);
        int lat;
        foreach (ts[i]) send(ts[i], lat);
        get_result(nm, ts[ts.size()-1].ed, ts[ts.size()-1].ee);
    endtask

    initial begin
        int lat;
        int k;
        vec_t seq[$];

        // table: tokens, expected value/err carried on the last token
        vecs = '{V(2), O(OP_ADD), V(3), O(OP_MUL), L(V(4), 14, ERR_NONE)};
        names.push_back("prec");
        vecs = {vecs, V(7), O(OP_SUB), V(2), O(OP_SUB), L(V(1), 4, ERR_NONE)};
        names.push_back("left_assoc");
        vecs = {vecs, O(OP_LPAREN), V(2), O(OP_ADD), V(3), O(OP_RPAREN),
                O(OP_MUL), L(V(4), 20, ERR_NONE)};
        names.push_back("paren");
        vecs = {vecs, V(-7), O(OP_DIV), L(V(2), 32'hFFFF_FFFD, ERR_NONE)};
        names.push_back("neg_div");
        vecs = {vecs, V(5), O(OP_DIV), V(0), O(OP_ADD), L(V(1), 0, ERR_DIV0)};
        names.push_back("div0");
        vecs = {vecs, V(1), O(OP_ADD), L(V(1), 2, ERR_NONE)};
        names.push_back("after_err");
        vecs = {vecs, O(OP_LPAREN), O(OP_LPAREN), O(OP_LPAREN), O(OP_LPAREN),
                L(O(OP_LPAREN), 0, ERR_OVF)};
        names.push_back("ovf");
        vecs = {vecs, V(1), L(O(OP_RPAREN), 0, ERR_PAREN)};
        names.push_back("rparen");
        vecs = {vecs, O(OP_LPAREN), L(V(1), 0, ERR_PAREN)};
        names.push_back("lparen_left");
        vecs = {vecs, O(OP_ADD), L(V(1), 0, ERR_UNF)};
        names.push_back("unf");
        vecs = {vecs, V(32'h8000_0000), O(OP_DIV),
                L(V(32'hFFFF_FFFF), 32'h8000_0000, ERR_NONE)};
        names.push_back("min_div");
        vecs = {vecs, V(6), O(OP_DIV), V(2), O(OP_MUL), L(V(3), 9, ERR_NONE)};
        names.push_back("muldiv_assoc");
        vecs = {vecs, V(2), O(OP_MUL), O(OP_LPAREN), V(3), O(OP_ADD), V(4),
                O(OP_RPAREN), O(OP_SUB), L(V(5), 9, ERR_NONE)};
        names.push_back("nested");
        vecs = {vecs, V(1), O(3'd7), L(V(2), 0, ERR_BADOP)};
        names.push_back("op7");
`ifdef EXPR_MOD_OP_EN
        vecs = {vecs, V(-7), O(OP_MOD), L(V(3), 32'hFFFF_FFFF, ERR_NONE)};
`else
        vecs = {vecs, V(-7), O(OP_MOD), L(V(3), 0, ERR_BADOP)};
`endif
        names.push_back("mod");

        // reset state
        #12;
        chk("rst_ack", {31'd0, input_ack}, 32'd0);
        chk("rst_stb", {31'd0, result_stb}, 32'd0);
        chk("rst_data", result_data, 32'd0);
        chk("rst_err", {29'd0, result_err}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        k = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i], lat);
            if (vecs[i].last) begin
                get_result(names[k], vecs[i].ed, vecs[i].ee);
                k++;
            end
        end

        // token-to-ack latency: 1 + reductions triggered
        send(V(2), lat);
        chk("lat_operand", lat, 1);
        send(O(OP_MUL), lat);
        chk("lat_push_op", lat, 1);
        send(V(3), lat);
        send(O(OP_ADD), lat);
        chk("lat_one_reduce", lat, 2);
        send(L(V(1), 7, ERR_NONE), lat);
        get_result("lat_expr", 7, ERR_NONE);

        // result held while result_ack low; next token must wait
        seq = '{V(1), O(OP_ADD), L(V(1), 2, ERR_NONE)};
        foreach (seq[i]) send(seq[i], lat);
        lat = 0;
        while (!result_stb && lat < 50) begin
            @(posedge CLK); #1;
            lat++;
        end
        input_stb = 1'b1;
        is_input_operator = 1'b0;
        input_data = 32'd5;
        input_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            chk("hold_stb", {31'd0, result_stb}, 32'd1);
            chk("hold_data", result_data, 32'd2);
            chk("hold_err", {29'd0, result_err}, 32'd0);
            chk("hold_noack", {31'd0, input_ack}, 32'd0);
        end
        result_ack = 1'b1;
        @(posedge CLK); #1;
        result_ack = 1'b0;
        chk("hold_drop", {31'd0, result_stb}, 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge CLK); #1;
            lat++;
            if (input_ack) break;
        end
        chk("hold_then_ack", lat, 1);
        input_stb = 1'b0;
        input_last = 1'b0;
        get_result("held_token", 5, ERR_NONE);

        // async reset during final reductions
        seq = '{V(1), O(OP_ADD), V(2), O(OP_MUL), L(V(3), 0, ERR_NONE)};
        foreach (seq[i]) send(seq[i], lat);
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_ack", {31'd0, input_ack}, 32'd0);
        chk("mid_rst_stb", {31'd0, result_stb}, 32'd0);
        chk("mid_rst_data", result_data, 32'd0);
        chk("mid_rst_err", {29'd0, result_err}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_expr("post_rst", '{V(4), O(OP_MUL), L(V(4), 16, ERR_NONE)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
